// File: rtl/mem_ld_data_ret.sv
// Load-data return unit for the MEMORY stage. It issues a read to data memory and returns the bytes to MEM/WB.
// When MEM_LD_TIMEOUT_EN is defined, a read timeout (TIMEOUT_CYC cycles) and a sticky ld_err flag are added.
module mem_ld_data_ret #(
  parameter int ADDR_W      = 12
`ifdef MEM_LD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_sel,
  input  logic              flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [11:0]       mem_rd_data,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_we_top,
  output logic              wb_we_bot,
  output logic [7:0]        wb_data_top,
  output logic [7:0]        wb_data_bot,
  output logic              ld_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          we_q, we_d;
  logic [3:0]          top_q, top_d;
  logic [7:0]          bot_q, bot_d;
  logic                ld_acc;
  logic                timeout_hit;

  // A load with no byte selected is not a load at all. A flush drops any load presented in the same cycle.
  assign ld_acc = ld_req & (|ld_sel) & ~flush;

`ifdef MEM_LD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The count holds the number of RD cycles already spent. The last allowed cycle gives up.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_RD) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!flush && !mem_rd_ack && timeout_hit) err_d = 1'b1;
    end else if (ld_acc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ld_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ld_err      = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    top_d   = top_q;
    bot_d   = bot_q;
    unique case (state_q)
      S_IDLE, S_RSP: begin
        state_d = S_IDLE;
        if (ld_acc) begin
          addr_d  = ld_addr;
          sel_d   = ld_sel;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_rd_ack) begin
          top_d   = mem_rd_data[11:8];
          bot_d   = mem_rd_data[7:0];
          we_d    = sel_q;
          state_d = S_RSP;
        end else if (timeout_hit) begin
          top_d   = '0;
          bot_d   = '0;
          we_d    = '0;
          state_d = S_RSP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments, so every flop samples its pre-edge value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      we_q    <= '0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
    end
  end

  assign mem_rd_en   = (state_q == S_RD);
  assign mem_addr    = addr_q;
  assign stall       = (state_q == S_RD) | ld_acc;
  assign wb_valid    = (state_q == S_RSP);
  assign wb_we_top   = wb_valid & we_q[1];
  assign wb_we_bot   = wb_valid & we_q[0];
  assign wb_data_top = {4'b0000, top_q};
  assign wb_data_bot = bot_q;

endmodule
